// File: rtl/cache_miss_handler.sv
// Per-request cache controller: tag lookup, per-set tree-PLRU victim choice,
// block fetch from memory, beat-by-beat fill into the victim way, one-cycle response.
module cache_miss_handler #(
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned BLOCK_SIZE     = 32,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    localparam int unsigned OFF       = $clog2(BLOCK_SIZE),
    localparam int unsigned IDX       = $clog2(NUM_SETS),
    localparam int unsigned TAG_WIDTH = ADDRESS_WIDTH - IDX - OFF,
    localparam int unsigned BEATS     = BLOCK_SIZE * 8 / MEM_DATA_WIDTH,
    localparam int unsigned BEAT_W    = $clog2(BEATS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    output logic [IDX-1:0]            lookup_index,
    output logic [TAG_WIDTH-1:0]      lookup_tag,
    input  logic                      lookup_hit,
    input  logic [NUM_WAYS-1:0]       lookup_hit_way,
    input  logic [NUM_WAYS-1:0]       way_valid,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDRESS_WIDTH-1:0]  mem_req_addr,
    input  logic                      mem_rsp_valid,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data,
    output logic                      fill_we,
    output logic [NUM_WAYS-1:0]       fill_way,
    output logic [IDX-1:0]            fill_index,
    output logic [TAG_WIDTH-1:0]      fill_tag,
    output logic [BEAT_W-1:0]         fill_beat,
    output logic [MEM_DATA_WIDTH-1:0] fill_data,
    output logic                      fill_done,
    output logic                      resp_valid,
    output logic                      resp_hit,
    output logic [NUM_WAYS-1:0]       resp_way
);

    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned BLK_W = ADDRESS_WIDTH - OFF;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, FILL, DONE, RESP} state_t;
    typedef logic [NUM_WAYS-1:1] tree_t;

    state_t              state_q, state_d;
    logic [BLK_W-1:0]    blk_q;
    logic [NUM_WAYS-1:0] way_q;
    logic                hit_q;
    logic [BEAT_W-1:0]   beat_q;
    tree_t               plru_q [NUM_SETS];

    logic [IDX-1:0]       index;
    logic [NUM_WAYS-1:0]  invalid_ways;
    logic [NUM_WAYS-1:0]  first_invalid;
    logic [NUM_WAYS-1:0]  first_hit;
    logic [NUM_WAYS-1:0]  victim;
    logic                 last_beat;
    logic                 unused;

    // Walk from the root; the node number shifted left collects the way index.
    function automatic logic [WAY_W-1:0] plru_victim(input tree_t tree);
        logic [WAY_W-1:0] node;
        node = WAY_W'(1);
        for (int l = 0; l < int'(WAY_W); l++) begin
            node = WAY_W'({node, tree[node]});
        end
        return node;
    endfunction

    function automatic tree_t plru_touch(input tree_t tree, input logic [WAY_W-1:0] way);
        tree_t            t;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] w;
        t    = tree;
        node = WAY_W'(1);
        w    = way;
        for (int l = 0; l < int'(WAY_W); l++) begin
            t[node] = ~w[WAY_W-1];
            node    = WAY_W'({node, w[WAY_W-1]});
            w       = w << 1;
        end
        return t;
    endfunction

    function automatic logic [WAY_W-1:0] onehot_to_idx(input logic [NUM_WAYS-1:0] oh);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
            if (oh[i]) idx = WAY_W'(i);
        end
        return idx;
    endfunction

    assign unused = ^req_addr[OFF-1:0];

    assign index         = blk_q[IDX-1:0];
    assign invalid_ways  = ~way_valid;
    assign first_invalid = invalid_ways & (~invalid_ways + NUM_WAYS'(1));
    assign first_hit     = lookup_hit_way & (~lookup_hit_way + NUM_WAYS'(1));
    assign victim        = (|invalid_ways) ? first_invalid
                                           : (NUM_WAYS'(1) << plru_victim(plru_q[index]));
    assign last_beat     = mem_rsp_valid && (beat_q == BEAT_W'(BEATS - 1));

    assign lookup_index = index;
    assign lookup_tag   = blk_q[BLK_W-1 -: TAG_WIDTH];
    assign mem_req_addr = {blk_q, OFF'(0)};
    assign fill_way     = way_q;
    assign fill_index   = index;
    assign fill_tag     = blk_q[BLK_W-1 -: TAG_WIDTH];
    assign fill_beat    = beat_q;
    assign fill_data    = mem_rsp_data;
    assign resp_hit     = hit_q;
    assign resp_way     = way_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        fill_we       = 1'b0;
        fill_done     = 1'b0;
        resp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP:  state_d = lookup_hit ? RESP : MEM_REQ;
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = FILL;
            end
            FILL: begin
                fill_we = mem_rsp_valid;
                if (last_beat) state_d = DONE;
            end
            DONE: begin
                fill_done = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request, way, beat counter and replacement state.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q  <= '0;
            way_q  <= '0;
            hit_q  <= 1'b0;
            beat_q <= '0;
            for (int s = 0; s < int'(NUM_SETS); s++) plru_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) blk_q <= req_addr[ADDRESS_WIDTH-1:OFF];
                LOOKUP: begin
                    hit_q <= lookup_hit;
                    way_q <= lookup_hit ? first_hit : victim;
                end
                FILL: if (mem_rsp_valid) beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                RESP: if (|way_q) plru_q[index] <= plru_touch(plru_q[index], onehot_to_idx(way_q));
                default: ;
            endcase
        end
    end

endmodule
